// File: rtl/csr_timer_bank.sv
// Bank of NUM_CH prescaled down-counters behind a CSR port, with per-channel pending flags.
// Reads are combinational; a write takes effect at the next clk edge. There is no backpressure.
module csr_timer_bank #(
    parameter int          NUM_CH = 4,
    parameter int          CNT_W  = 32,
    parameter logic [13:0] BASE   = 14'h041
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              csr_we,
    input  logic [13:0]       csr_num,
    input  logic [31:0]       csr_wmask,
    input  logic [31:0]       csr_wvalue,
    output logic [31:0]       csr_rvalue,
    output logic              csr_hit,
    output logic [NUM_CH-1:0] timer_int,
    output logic              timer_int_any
);

    localparam logic [13:0]      TSTAT_OFF = 14'(4 * NUM_CH);
    localparam logic [CNT_W-1:0] ONES      = '1;

    logic [13:0]       w_off;
    logic              w_above;
    logic              w_ch_hit;
    logic              w_stat_hit;
    logic [11:0]       w_ch_idx;
    logic [1:0]        w_reg;
    logic [NUM_CH-1:0] w_pend;
    logic [3:0]        w_cfg_q  [NUM_CH];
    logic [CNT_W-1:0]  w_init_q [NUM_CH];
    logic [CNT_W-1:0]  w_cnt_q  [NUM_CH];

    assign w_off      = csr_num - BASE;
    assign w_above    = (csr_num >= BASE);
    assign w_ch_hit   = w_above && (w_off < TSTAT_OFF);
    assign w_stat_hit = w_above && (w_off == TSTAT_OFF);
    assign w_ch_idx   = w_off[13:2];
    assign w_reg      = w_off[1:0];
    assign csr_hit    = w_ch_hit | w_stat_hit;

    function automatic logic [3:0] f_div_m1(input logic [1:0] presc);
        case (presc)
            2'b00:   f_div_m1 = 4'd0;
            2'b01:   f_div_m1 = 4'd1;
            2'b10:   f_div_m1 = 4'd3;
            default: f_div_m1 = 4'd15;
        endcase
    endfunction

    for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
        localparam logic [11:0] IDX = 12'(g);

        logic [3:0]       r_cfg;
        logic [CNT_W-1:0] r_init;
        logic [CNT_W-1:0] r_cnt;
        logic [3:0]       r_pre;
        logic             r_pend;

        logic             w_sel;
        logic             w_cfg_wr;
        logic             w_init_wr;
        logic             w_clr_wr;
        logic [3:0]       w_cfg_new;
        logic [CNT_W-1:0] w_init_new;
        logic             w_pt;
        logic             w_run;
        logic             w_uf;

        assign w_sel      = csr_we && w_ch_hit && (w_ch_idx == IDX);
        assign w_cfg_wr   = w_sel && (w_reg == 2'd0);
        assign w_init_wr  = w_sel && (w_reg == 2'd1);
        assign w_clr_wr   = w_sel && (w_reg == 2'd3) && csr_wmask[0] && csr_wvalue[0];
        assign w_cfg_new  = (csr_wmask[3:0] & csr_wvalue[3:0]) | (~csr_wmask[3:0] & r_cfg);
        assign w_init_new = (csr_wmask[CNT_W-1:0] & csr_wvalue[CNT_W-1:0])
                          | (~csr_wmask[CNT_W-1:0] & r_init);

        // A stopped one-shot (counter all-ones) never ticks; any TCFG write preempts this edge's tick.
        assign w_pt  = r_cfg[0] && (r_pre == f_div_m1(r_cfg[3:2]));
        assign w_run = w_pt && (r_cnt != ONES) && !w_cfg_wr;
        assign w_uf  = w_run && (r_cnt == '0);

        always_ff @(posedge clk or negedge resetn) begin
            if (!resetn) begin
                r_cfg  <= '0;
                r_init <= '0;
                r_cnt  <= ONES;
                r_pre  <= '0;
                r_pend <= 1'b0;
            end else begin
                if (w_init_wr) r_init <= w_init_new;
                if (w_cfg_wr) begin
                    r_cfg <= w_cfg_new;
                    if (w_cfg_new[0]) begin
                        r_cnt <= r_init;
                        r_pre <= '0;
                    end
                end else if (r_cfg[0]) begin
                    r_pre <= w_pt ? 4'd0 : r_pre + 4'd1;
                    if (w_run) begin
                        if (r_cnt == '0) r_cnt <= r_cfg[1] ? r_init : ONES;
                        else             r_cnt <= r_cnt - 1'b1;
                    end
                end
                if (w_uf)          r_pend <= 1'b1;
                else if (w_clr_wr) r_pend <= 1'b0;
            end
        end

        assign w_pend[g]   = r_pend;
        assign w_cfg_q[g]  = r_cfg;
        assign w_init_q[g] = r_init;
        assign w_cnt_q[g]  = r_cnt;
    end

    always_comb begin
        csr_rvalue = '0;
        if (w_stat_hit) begin
            csr_rvalue[NUM_CH-1:0] = w_pend;
        end else if (w_ch_hit) begin
            for (int c = 0; c < NUM_CH; c++) begin
                if (w_ch_idx == 12'(c)) begin
                    case (w_reg)
                        2'd0:    csr_rvalue[3:0]       = w_cfg_q[c];
                        2'd1:    csr_rvalue[CNT_W-1:0] = w_init_q[c];
                        2'd2:    csr_rvalue[CNT_W-1:0] = w_cnt_q[c];
                        default: csr_rvalue            = '0;
                    endcase
                end
            end
        end
    end

    assign timer_int     = w_pend;
    assign timer_int_any = |w_pend;

endmodule

// File: doc/csr_timer_bank.md
CSR_TIMER_BANK -- requirements
Module: csr_timer_bank

Interface
REQ-001 SHALL have parameter NUM_CH, default 4, number of timer channels, legal range 1..8.
REQ-002 SHALL have parameter CNT_W, default 32, counter width, legal range 16..32.
REQ-003 SHALL have parameter BASE, default 14'h041, CSR number of channel 0 TCFG.
REQ-004 SHALL have port clk  input  1  single clock; all state changes on its rising edge.
REQ-005 SHALL have port resetn  input  1  reset; one clock, reset is asynchronous and active-low.
REQ-006 SHALL have port csr_we  input  1  CSR write strobe.
REQ-007 SHALL have port csr_num  input  14  CSR number for both read and write.
REQ-008 SHALL have port csr_wmask  input  32  per-bit write enable.
REQ-009 SHALL have port csr_wvalue  input  32  write data.
REQ-010 SHALL have port csr_rvalue  output  32  read data, combinational.
REQ-011 SHALL have port csr_hit  output  1  csr_num decodes to a register of this block.
REQ-012 SHALL have port timer_int  output  NUM_CH  registered per-channel pending flags.
REQ-013 SHALL have port timer_int_any  output  1  OR of timer_int.

Function
REQ-014 SHALL map channel c at BASE+4c: +0 TCFG, +1 INITVAL, +2 TVAL (read-only), +3 TICLR; BASE+4*NUM_CH is TSTAT (read-only).
REQ-015 SHALL define TCFG bit0 EN, bit1 PERIODIC, bits[3:2] PRESC (00 div1, 01 div2, 10 div4, 11 div16); bits[31:4] read 0.
REQ-016 SHALL make INITVAL CNT_W bits wide, with bits above CNT_W reading 0; TVAL reads the zero-extended counter.
REQ-017 SHALL read TICLR as 0; a write with wmask[0]&wvalue[0] clears that channel's pending flag.
REQ-018 SHALL read TSTAT as {zeros, pending[NUM_CH-1:0]}; writes to TSTAT and TVAL are ignored.
REQ-019 SHALL apply every write as new = wmask&wvalue | ~wmask&old, effective at the next edge; a same-cycle read returns the old value.
REQ-020 SHALL return 0 with csr_hit=0 for unmapped csr_num.
REQ-021 SHALL, on a TCFG write whose resulting EN=1, load the counter with INITVAL (the new value if INITVAL is written the same cycle is NOT used; the current INITVAL is) and clear the prescaler.
REQ-022 SHALL keep per-channel 4-bit prescaler; tick = EN & (pre == div-1); pre increments while EN, wraps to 0 on tick.
REQ-023 SHALL, on tick with counter != 0 and != all-ones, decrement the counter.
REQ-024 SHALL, on tick with counter == 0: set pending; PERIODIC=1 reload INITVAL; PERIODIC=0 go to all-ones and halt.
REQ-025 SHALL not tick a counter at all-ones (stopped one-shot) until the next TCFG enable write.
REQ-026 SHALL freeze counter and prescaler while EN=0; re-enable via TCFG write reloads per REQ-021.
REQ-027 SHALL not disturb a running count on INITVAL write; the new value is used at the next reload.
REQ-028 SHALL give set priority over TICLR clear when both occur in the same cycle (pending stays 1).
REQ-029 SHALL yield periodic interrupt spacing of (INITVAL+1)*div cycles; INITVAL=0 with div1 pends every cycle.
REQ-030 SHALL drive timer_int directly from the pending flops and timer_int_any as their OR.

Reset
REQ-031 SHALL, while resetn=0, asynchronously force TCFG=0, INITVAL=0, prescalers=0, pending=0, counters=all-ones (CNT_W bits).
REQ-032 SHALL have timer_int=0 and timer_int_any=0 immediately on resetn falling, independent of clk.
REQ-033 SHALL leave csr_rvalue/csr_hit purely combinational from state and csr_num during and after reset.

Verification
REQ-034 SHALL cover reset: after release, read TCFG/INITVAL/TSTAT -> 0; TVAL ch0 -> 0xFFFFFFFF (CNT_W=32); timer_int=0.
REQ-035 SHALL cover one-shot: ch0 INITVAL=3, TCFG=0x1 -> TVAL 3,2,1,0 on successive cycles, then 0xFFFFFFFF with timer_int[0]=1, held; TICLR write bit0 -> timer_int[0]=0, no further pends.
REQ-036 SHALL cover periodic prescale: ch1 INITVAL=2, TCFG=0xB (div4, periodic, EN) -> timer_int[1] sets every 12 cycles, cleared by TICLR in between.
REQ-037 SHALL cover collision: TICLR write to ch1 in the same cycle as its underflow -> timer_int[1] remains 1.
REQ-038 SHALL cover pause: write TCFG EN=0 when TVAL=5 -> TVAL holds 5 for 10 cycles; TCFG EN=1 -> TVAL=INITVAL next cycle.
REQ-039 SHALL cover async reset mid-count: pull resetn low between edges with timer_int=4'b0101 -> outputs 0 before next edge; TVAL all-ones after release.
